rls_shift_seq: RTL and testbench
================================

// Module: rls_shift_seq
// PURPOSE
//   Parametrised sequential shift/rotate unit: next generation of the 8-bit logical shifter.
//   Adds width parameter, arithmetic and rotate modes, a carry-out flag and a valid/ready handshake.
//   Shifts iteratively, STEP positions per cycle. Sits between the register file and the ALU result mux.
// PARAMETERS
//   WIDTH  8  data width; power of two, >= 4
//   STEP   1  max positions shifted per SHIFT cycle; 1..WIDTH/2
//   AMT_W  $clog2(WIDTH)  shift-amount width (localparam, derived)
// PORTS
//   clk        in   1      rising-edge clock
//   clear      in   1      asynchronous active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request (state IDLE)
//   in_data    in   WIDTH  operand
//   in_amount  in   AMT_W  shift count 0..WIDTH-1
//   in_dir     in   1      0 = right, 1 = left
//   in_mode    in   2      00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer takes result
//   out_data   out  WIDTH  result
//   out_carry  out  1      last bit shifted or rotated out; 0 when amount = 0
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; out_data, out_carry, out_valid, busy = 0; in_ready = 1. Clock and reset are fixed:
//     one clock clk; clear is asynchronous, active-high; a mid-operation clear aborts and drops the result.
//   FSM: IDLE -> SHIFT on in_valid&in_ready if in_amount != 0, else IDLE -> DONE directly.
//     SHIFT: each cycle shift by n = min(STEP, rem); rem -= n; rem becomes 0 -> DONE.
//     DONE: out_valid = 1; out_ready -> IDLE. No new request is accepted in the same cycle as release.
//   Capture: data, amount, dir and mode are registered on accept. Later input changes have no effect.
//   Latency: accept edge to out_valid = 1 + ceil(amount/STEP) cycles.
//   Outputs: out_data and out_carry are stable while out_valid = 1.
//     out_data shows the working register in all states.
//   Logical: vacated bits are filled with 0.
//   Arithmetic: a right shift fills with the captured MSB. A left shift is identical to logical.
//   Rotate: no bits are lost. out_carry = last bit that crossed the boundary.
//   in_valid while busy: ignored, because in_ready = 0. No queueing.
// CONFIGURATION
//   RLS_BARREL_EN defined: the SHIFT state always lasts exactly one cycle and uses a full log2(WIDTH)-stage barrel network.
//     Latency = 1 (amount 0) or 2 (amount != 0), independent of STEP, and STEP is ignored.
//   RLS_BARREL_EN undefined: the iterative STEP-per-cycle datapath is used (lower area).
//   Results and carry are bit-identical in both builds; only the timing differs.
// STRUCTURE
//   Shared include rls_shift_defs.vh holds the mode codes (MODE_LSL/ASR/ROT) and the state encodings (IDLE/SHIFT/DONE).
//   Sub-module rls_shift_step is combinational. It shifts by 0..STEP (or by 0..WIDTH-1 under RLS_BARREL_EN)
//     for a given dir and mode, and returns data plus carry.
//   The top level keeps the FSM, the rem counter, the captured controls and the handshake.
// TESTING (WIDTH=8, STEP=1 unless noted)
//   Reset: assert clear mid-SHIFT -> immediately busy=0, out_valid=0, in_ready=1, out_data=0.
//   Logical right: 0x96, amt 3, dir 0, mode 00 -> 0x12, carry 1, out_valid 4 cycles after accept.
//   Arithmetic right: 0x96, amt 2, mode 01 -> 0xE5, carry 1.
//     Same operand with dir 1 -> 0x58, carry 0.
//   Rotate left: 0x81, amt 1 -> 0x03, carry 1.
//     STEP=2, amt 7, rotate right 0x01 -> 0x02, carry 0, latency 5.
//   Amount 0: 0xA5 -> 0xA5, carry 0, latency 1.
//     RLS_BARREL_EN build, amt 7 -> latency 2 with the same result.
//   Backpressure: hold out_ready=0 for 5 cycles -> out_valid and data stay stable, in_ready=0,
//     a new in_valid is ignored, and release occurs on the first out_ready.

Source files
------------

// File: rtl/rls_shift_seq_pkg.sv
// ============================================================================
// rls_shift_seq_pkg : mode codes and FSM state encoding for rls_shift_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rls_shift_seq_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rls_shift_step.sv
// ============================================================================
// rls_shift_step : combinational shift/rotate by 0..WIDTH-1 with carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rls_shift_step
    import rls_shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [2*WIDTH-1:0] w_ext;
    logic [WIDTH-1:0]   w_fill;
    logic [AMT_W:0]     w_sh;
    logic [AMT_W-1:0]   w_idx;

    // Left shifts are done as a right shift of {data, fill} by WIDTH-amount,
    // so both directions share one funnel and no result bits go unused.
    always_comb begin
        w_fill = '0;
        w_ext  = '0;
        w_sh   = '0;
        w_idx  = '0;
        result = data;
        carry  = 1'b0;
        if (mode == MODE_ROT) begin
            w_fill = data;
        end else if (mode == MODE_ASR && !dir) begin
            w_fill = {WIDTH{data[WIDTH-1]}};
        end
        if (dir) begin
            w_ext = {data, w_fill};
            w_sh  = (AMT_W+1)'(WIDTH) - {1'b0, amount};
            w_idx = AMT_W'(0) - amount;
        end else begin
            w_ext = {w_fill, data};
            w_sh  = {1'b0, amount};
            w_idx = amount - AMT_W'(1);
        end
        result = WIDTH'(w_ext >> w_sh);
        if (amount != '0) begin
            carry = data[w_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rls_shift_seq.sv
// ============================================================================
// rls_shift_seq : sequential shift/rotate unit with valid/ready handshake.
// Optional macro RLS_BARREL_EN: single-cycle barrel SHIFT state (STEP unused).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rls_shift_seq
    import rls_shift_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [AMT_W-1:0] r_rem;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] w_n;
    logic [AMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;

`ifdef RLS_BARREL_EN
    assign w_n = r_rem;
`else
    localparam logic [AMT_W-1:0] c_STEP = AMT_W'(STEP);
    assign w_n = (r_rem > c_STEP) ? c_STEP : r_rem;
`endif
    assign w_rem_next = r_rem - w_n;

    rls_shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data   (r_data),
        .amount (w_n),
        .dir    (r_dir),
        .mode   (r_mode),
        .result (w_step_data),
        .carry  (w_step_carry)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = (in_amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Carry is cleared on accept so a zero-amount request reports carry 0.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= MODE_LSL;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_data  <= in_data;
            r_carry <= 1'b0;
            r_rem   <= in_amount;
            r_dir   <= in_dir;
            r_mode  <= in_mode;
        end else if (r_state == ST_SHIFT) begin
            r_data  <= w_step_data;
            r_carry <= w_step_carry;
            r_rem   <= w_rem_next;
        end
    end

    assign out_data  = r_data;
    assign out_carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_rls_shift_seq.sv
// ============================================================================
// tb_rls_shift_seq : randomized self-checking bench, STEP=1 and STEP=2 units.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rls_shift_seq;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic [1:0]      in_valid;
    logic [1:0][7:0] in_data;
    logic [1:0][2:0] in_amount;
    logic [1:0]      in_dir;
    logic [1:0][1:0] in_mode;
    logic [1:0]      out_ready;
    wire  [1:0]      in_ready;
    wire  [1:0]      out_valid;
    wire  [1:0][7:0] out_data;
    wire  [1:0]      out_carry;
    wire  [1:0]      busy;

    int checks = 0;
    int errors = 0;

    rls_shift_seq #(.WIDTH(8), .STEP(1)) dut (
        .clk(clk), .clear(clear),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_amount(in_amount[0]), .in_dir(in_dir[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_carry(out_carry[0]), .busy(busy[0])
    );

    rls_shift_seq #(.WIDTH(8), .STEP(2)) dut2 (
        .clk(clk), .clear(clear),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_amount(in_amount[1]), .in_dir(in_dir[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_carry(out_carry[1]), .busy(busy[1])
    );

    // Reference: move one bit at a time, remembering the last bit that left.
    function automatic void model(input logic [7:0] d, input int amt, input logic dir,
                                  input logic [1:0] mode, output logic [7:0] r, output logic c);
        logic fill;
        r = d;
        c = 1'b0;
        for (int k = 0; k < amt; k++) begin
            if (dir) begin
                c = r[7];
                r = {r[6:0], (mode == 2'b10) ? c : 1'b0};
            end else begin
                c = r[0];
                fill = (mode == 2'b10) ? c : ((mode == 2'b01) ? d[7] : 1'b0);
                r = {fill, r[7:1]};
            end
        end
    endfunction

    function automatic int exp_lat(input int amt, input int step);
`ifdef RLS_BARREL_EN
        return (amt == 0) ? 1 : 2;
`else
        return 1 + (amt + step - 1) / step;
`endif
    endfunction

    task automatic do_op(input int s, input logic [7:0] d, input int amt, input logic dir,
                         input logic [1:0] mode, output logic [7:0] rd, output logic rc,
                         output int lat, output logic acc_ok);
        acc_ok       = in_ready[s];
        in_data[s]   = d;
        in_amount[s] = 3'(amt);
        in_dir[s]    = dir;
        in_mode[s]   = mode;
        in_valid[s]  = 1'b1;
        @(posedge clk); #1;
        in_valid[s]  = 1'b0;
        in_data[s]   = 8'($urandom);
        in_amount[s] = 3'($urandom);
        in_dir[s]    = 1'($urandom);
        in_mode[s]   = 2'($urandom);
        lat = 1;
        while (!out_valid[s] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = out_data[s];
        rc = out_carry[s];
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy[0], out_valid[0], in_ready[0], out_data[0], out_carry[0]} !== {3'b001, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b ready=%b data=%h carry=%b, want 0 0 1 00 0",
                     busy[0], out_valid[0], in_ready[0], out_data[0], out_carry[0]);
        end
        @(negedge clk) clear = 1'b0;
        @(posedge clk); #1;
        in_data[0] = 8'hC3; in_amount[0] = 3'd5; in_dir[0] = 1'b0; in_mode[0] = 2'b00;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b want 1", busy[0]);
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({busy[0], out_valid[0], in_ready[0], out_data[0]} !== {3'b001, 8'h00}) begin
            errors++;
            $display("FAIL mid_shift_clear: busy=%b valid=%b ready=%b data=%h, want 0 0 1 00",
                     busy[0], out_valid[0], in_ready[0], out_data[0]);
        end
        @(negedge clk) clear = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL aborted_result_dropped: valid=%b busy=%b want 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_directed();
        logic [7:0] dv [7] = '{8'h96, 8'h96, 8'h96, 8'h81, 8'hA5, 8'hA5, 8'h96};
        int         av [7] = '{3, 2, 2, 1, 0, 7, 3};
        logic       rv [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] mv [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
        logic [7:0] ed [7] = '{8'h12, 8'hE5, 8'h58, 8'h03, 8'hA5, 8'hD2, 8'h12};
        logic       ec [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] rd;
        logic rc, ok;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(0, dv[i], av[i], rv[i], mv[i], rd, rc, lat, ok);
            checks++;
            if (rd !== ed[i] || rc !== ec[i] || lat != exp_lat(av[i], 1)) begin
                errors++;
                $display("FAIL directed_%0d: data=%h carry=%b lat=%0d, want %h %b %0d",
                         i, rd, rc, lat, ed[i], ec[i], exp_lat(av[i], 1));
            end
        end
    endtask

    task automatic test_step2();
        logic [7:0] rd;
        logic rc, ok;
        int lat;
        do_op(1, 8'h01, 7, 1'b0, 2'b10, rd, rc, lat, ok);
        checks++;
        if (rd !== 8'h02 || rc !== 1'b0 || lat != exp_lat(7, 2)) begin
            errors++;
            $display("FAIL step2_rotr7: data=%h carry=%b lat=%0d, want 02 0 %0d", rd, rc, lat, exp_lat(7, 2));
        end
    endtask

    task automatic test_random();
        logic [7:0] d, rd, md;
        logic rc, mc, ok, dir;
        logic [1:0] mode;
        int amt, lat, s;
        for (int i = 0; i < 60; i++) begin
            s    = i % 2;
            d    = 8'($urandom);
            amt  = int'($urandom_range(0, 7));
            dir  = 1'($urandom);
            mode = 2'($urandom);
            model(d, amt, dir, mode, md, mc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_op(s, d, amt, dir, mode, rd, rc, lat, ok);
            checks++;
            if (ok !== 1'b1 || rd !== md || rc !== mc || lat != exp_lat(amt, s + 1)) begin
                errors++;
                $display("FAIL random_%0d (u%0d d=%h a=%0d dir=%b m=%b): ready=%b data=%h carry=%b lat=%0d, want 1 %h %b %0d",
                         i, s, d, amt, dir, mode, ok, rd, rc, lat, md, mc, exp_lat(amt, s + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_data[0] = 8'h96; in_amount[0] = 3'd3; in_dir[0] = 1'b0; in_mode[0] = 2'b00;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'($urandom);
            in_amount[0] = 3'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h12 || out_carry[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: valid=%b data=%h carry=%b ready=%b, want 1 12 1 0",
                         c, out_valid[0], out_data[0], out_carry[0], in_ready[0]);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b busy=%b ready=%b, want 0 0 1",
                     out_valid[0], busy[0], in_ready[0]);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        in_amount = '0;
        in_dir    = '0;
        in_mode   = '0;
        out_ready = '0;
        clear     = 1'b1;
        test_reset();
        test_directed();
        test_step2();
        test_random();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
